// File: rtl/segment_demodulator.sv
// Per-segment correlating demodulator: accumulates segment*reference products over
// one symbol and decides the bit from the sign of the correlation sum.
module segment_demodulator #(
    parameter int SAMPLES_PER_SYMBOL = 4,
    parameter int DATA_WIDTH         = 32,
    parameter int ACC_WIDTH          = 72
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         sample_en,
    input  logic signed [DATA_WIDTH-1:0] segment_in,
    input  logic signed [DATA_WIDTH-1:0] ref_in,
    output logic                         bit_out,
    output logic signed [ACC_WIDTH-1:0]  corr_out,
    output logic                         valid,
    output logic                         busy
);

    localparam int PW    = 2 * DATA_WIDTH;
    localparam int CNT_W = $clog2(SAMPLES_PER_SYMBOL + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLES_PER_SYMBOL - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, OUT} state_t;

    state_t                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic        [CNT_W-1:0]     cnt_q, cnt_d;
    logic signed [PW-1:0]        prod_q, prod_d;
    logic                        pend_q, pend_d;
    logic                        bit_q, bit_d;
    logic signed [ACC_WIDTH-1:0] corr_q, corr_d;
    logic signed [ACC_WIDTH-1:0] prod_ext, acc_sum;

    // Multiply and accumulate are split across a register stage; pend_q marks a
    // product that still has to be folded into the accumulator.
    assign prod_ext = {{(ACC_WIDTH-PW){prod_q[PW-1]}}, prod_q};
    assign acc_sum  = acc_q + prod_ext;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        pend_d  = 1'b0;
        bit_d   = bit_q;
        corr_d  = corr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    prod_d  = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (pend_q) acc_d = acc_sum;
                if (sample_en) begin
                    prod_d = PW'(segment_in) * PW'(ref_in);
                    pend_d = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (pend_q) acc_d = acc_sum;
                corr_d  = acc_d;
                bit_d   = ~acc_d[ACC_WIDTH-1];
                state_d = OUT;
            end
            OUT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            pend_q  <= 1'b0;
            bit_q   <= 1'b0;
            corr_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            pend_q  <= pend_d;
            bit_q   <= bit_d;
            corr_q  <= corr_d;
        end
    end

    assign valid    = (state_q == OUT);
    assign busy     = (state_q != IDLE);
    assign bit_out  = bit_q;
    assign corr_out = corr_q;

endmodule

// File: tb/tb_segment_demodulator.sv
// Randomized self-checking bench for segment_demodulator against a sum-of-products model.
module tb_segment_demodulator;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 72;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 sample_en;
    logic signed [DW-1:0] segment_in;
    logic signed [DW-1:0] ref_in;
    logic                 bit_out;
    logic signed [AW-1:0] corr_out;
    logic                 valid;
    logic                 busy;

    int n_tests = 0;
    int n_fail  = 0;

    segment_demodulator #(
        .SAMPLES_PER_SYMBOL(N),
        .DATA_WIDTH(DW),
        .ACC_WIDTH(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .sample_en(sample_en),
        .segment_in(segment_in),
        .ref_in(ref_in),
        .bit_out(bit_out),
        .corr_out(corr_out),
        .valid(valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // vmode: 0 constant sc/rc, 1 random values. emode: 0 always enabled,
    // 1 random enables, 2 fixed pattern 1,0,0,1,1,0,1. poke: pulse start mid-symbol.
    task automatic run_symbol(input logic signed [DW-1:0] sc, input logic signed [DW-1:0] rc,
                              input int vmode, input int emode, input bit poke);
        logic signed [AW-1:0] sum;
        logic signed [63:0]   p;
        logic [6:0]           pat;
        logic signed [DW-1:0] s, r;
        int                   got_n, cyc;
        bit                   en;
        sum   = '0;
        got_n = 0;
        cyc   = 0;
        pat   = 7'b1011001;
        start      = 1'b1;
        sample_en  = 1'b1;  // must not be accepted alongside start
        segment_in = 32'sd12345;
        ref_in     = 32'sd999;
        step();
        start = 1'b0;
        chk("busy_after_start", AW'(busy), AW'(1));
        while (got_n < N && cyc < 200) begin
            case (emode)
                0:       en = 1'b1;
                1:       en = ($urandom_range(0, 2) != 0);
                default: en = pat[cyc % 7];
            endcase
            s = (vmode == 1) ? DW'($urandom) : sc;
            r = (vmode == 1) ? DW'($urandom) : rc;
            sample_en  = en;
            segment_in = s;
            ref_in     = r;
            start      = poke && (cyc == 1);
            step();
            cyc++;
            if (en) begin
                p   = 64'(s) * 64'(r);
                sum = sum + $signed({{(AW-64){p[63]}}, p});
                got_n++;
            end
            chk("no_valid_accum", AW'(valid), AW'(0));
            chk("busy_accum", AW'(busy), AW'(1));
        end
        start = 1'b0;
        if (got_n < N) begin
            chk("sample_budget", AW'(got_n), AW'(N));
            return;
        end
        // now in the flush cycle; these samples must be ignored
        sample_en  = 1'b1;
        segment_in = DW'($urandom);
        ref_in     = DW'($urandom);
        step();
        chk("valid_pulse", AW'(valid), AW'(1));
        chk("corr_out", corr_out, sum);
        chk("bit_out", AW'(bit_out), AW'(sum >= 0));
        chk("busy_out", AW'(busy), AW'(1));
        sample_en = 1'b0;
        step();
        chk("valid_drop", AW'(valid), AW'(0));
        chk("busy_drop", AW'(busy), AW'(0));
        chk("corr_hold", corr_out, sum);
        step();
        chk("no_second_valid", AW'(valid), AW'(0));
        chk("idle_busy", AW'(busy), AW'(0));
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        sample_en  = 1'b0;
        segment_in = '0;
        ref_in     = '0;
        #12;
        chk("rst_valid", AW'(valid), AW'(0));
        chk("rst_busy", AW'(busy), AW'(0));
        chk("rst_bit", AW'(bit_out), AW'(0));
        chk("rst_corr", corr_out, '0);
        reset = 1'b0;
        step();

        run_symbol(32'sd1000, 32'sd1000, 0, 0, 1'b0);
        run_symbol(-32'sd1000, 32'sd1000, 0, 0, 1'b0);
        run_symbol(32'sd1000, 32'sd1000, 1, 2, 1'b0);
        run_symbol(32'sd0, 32'sd1234, 0, 0, 1'b0);
        run_symbol(32'sd1, -32'sd3, 0, 1, 1'b1);
        run_symbol(32'sh8000_0000, 32'sh8000_0000, 0, 0, 1'b0);
        chk("min_neg_sq", corr_out, 72'h01_0000_0000_0000_0000);

        // abort mid-symbol after two accepted samples
        start = 1'b1;
        step();
        start      = 1'b0;
        sample_en  = 1'b1;
        segment_in = 32'sd100;
        ref_in     = 32'sd100;
        step();
        step();
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", AW'(busy), AW'(0));
        chk("abort_valid", AW'(valid), AW'(0));
        chk("abort_corr", corr_out, '0);
        #2 reset = 1'b0;
        sample_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_no_valid", AW'(valid), AW'(0));
        end
        run_symbol(32'sd5, 32'sd7, 0, 0, 1'b0);
        chk("fresh_corr", corr_out, 72'd140);

        for (int t = 0; t < 10; t++)
            run_symbol('0, '0, 1, 1, ($urandom_range(0, 1) == 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/segment_demodulator.md
# segment_demodulator

Receive-side counterpart of the per-segment modulation pipe. The modulator emits the reference waveform for a `1` bit and the mirrored reference for a `0` bit. This block correlates each received segment against the reference waveform over `SAMPLES_PER_SYMBOL` samples and recovers the bit. It reports the correlation value with it, and uses the same `start`/`valid`/`busy` handshake as the modulation stages.

## Interface
- `SAMPLES_PER_SYMBOL`, 4, samples accumulated per decided bit (2..256)
- `DATA_WIDTH`, 32, width of sample and reference words (signed two's complement)
- `ACC_WIDTH`, 72, correlation accumulator width (signed; ≥ 2*DATA_WIDTH + clog2(SAMPLES_PER_SYMBOL))

- `clk` input 1 — single clock; all state changes on its rising edge
- `reset` input 1 — asynchronous, active-high; clears all state
- `start` input 1 — begin a symbol; honoured only in IDLE
- `sample_en` input 1 — qualifies `segment_in`/`ref_in` this cycle
- `segment_in` input DATA_WIDTH — received segment sample, signed
- `ref_in` input DATA_WIDTH — reference waveform sample aligned with `segment_in`, signed
- `bit_out` output 1 — decided bit, valid while `valid`=1
- `corr_out` output ACC_WIDTH — signed correlation sum, valid while `valid`=1
- `valid` output 1 — one-cycle pulse, result available
- `busy` output 1 — high from start acceptance until the result cycle, inclusive

## Operation
- FSM states: IDLE, ACCUM, FLUSH, OUT.
- IDLE:
  - `start`=1 → clear accumulator, sample counter and product register; next state ACCUM.
  - `sample_en` is ignored in IDLE.
- ACCUM:
  - Each cycle with `sample_en`=1 registers `prod = segment_in * ref_in` (full 2*DATA_WIDTH signed) and increments the counter.
  - Each cycle with a product pending adds it, sign-extended, to the accumulator.
  - Cycles with `sample_en`=0 leave the counter unchanged and add nothing.
  - When the `SAMPLES_PER_SYMBOL`-th sample is accepted → FLUSH.
- FLUSH:
  - The last product is added to the accumulator.
  - Samples presented in this cycle are ignored.
  - Next state OUT.
- OUT:
  - `valid`=1, `bit_out = (acc >= 0)` (tie at 0 decides `1`), `corr_out = acc`.
  - Next state IDLE.
- `start` outside IDLE is ignored (no queuing).
- Accumulator arithmetic: two's complement wrap at ACC_WIDTH. With the default widths overflow cannot occur.
- `bit_out`/`corr_out` hold their last result after OUT until the next OUT or reset.

## Timing
- Reset values: state IDLE; `valid`=0, `busy`=0, `bit_out`=0, `corr_out`=0; accumulator, counter, product = 0.
- `busy`:
  - Rises in the cycle after `start` is sampled in IDLE.
  - Stays high through ACCUM, FLUSH and OUT.
  - Falls when IDLE is re-entered.
- If the final sample is accepted in cycle k:
  - FLUSH is cycle k+1.
  - `valid`, `bit_out` and `corr_out` are presented in cycle k+2 for exactly one cycle.
  - IDLE is cycle k+3; the earliest next `start` is sampled in k+3.
- Minimum symbol period with `sample_en` held high: `SAMPLES_PER_SYMBOL` + 3 cycles from `start` to the next accepted `start`.
- Reset asserted mid-symbol:
  - All outputs return to their reset values immediately (asynchronously).
  - No `valid` is generated for the aborted symbol.
  - Operation resumes on the first `start` after reset deasserts.
- `start` and the first `sample_en` in the same IDLE cycle: that sample is not accepted. Sampling begins in ACCUM.

## Test plan
- N=4, `ref_in`=1000 and `segment_in`=1000 on 4 consecutive cycles → `valid` 2 cycles after the 4th sample, `corr_out`=4,000,000, `bit_out`=1.
- Same but `segment_in`=-1000 (mirrored reference) → `corr_out`=-4,000,000, `bit_out`=0.
- `sample_en` toggling 1,0,0,1,1,0,1 → exactly 4 samples accepted; `busy` high throughout; `valid` exactly 2 cycles after the 4th accepted sample; one pulse only.
- `segment_in`=0 for all samples → `corr_out`=0, `bit_out`=1 (tie rule).
- `start` pulsed during ACCUM is ignored (one `valid` only). Reset asserted after 2 samples → `busy`/`valid`/`corr_out` = 0 at once. A fresh symbol afterwards with values +5 × +7 → `corr_out`=140, `bit_out`=1.
- `segment_in`=`ref_in`=-2^31 for 4 samples → `corr_out`=2^64 (positive, no wrap), `bit_out`=1.
